// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU op codes (also used by the control FSM),
// branch_op codes, the ALU FSM state encoding and the shifter mode.
package rv32i_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_ADDR = 5'b11000;
    localparam logic [4:0] ALU_SUB  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b01010;
    localparam logic [4:0] ALU_OR   = 5'b01100;
    localparam logic [4:0] ALU_XOR  = 5'b01101;
    localparam logic [4:0] ALU_SLL  = 5'b01110;
    localparam logic [4:0] ALU_SRL  = 5'b01111;
    localparam logic [4:0] ALU_SRA  = 5'b10000;
    localparam logic [4:0] ALU_SLT  = 5'b10001;
    localparam logic [4:0] ALU_SLTU = 5'b10010;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b001;
    localparam logic [2:0] BR_NE   = 3'b010;
    localparam logic [2:0] BR_LT   = 3'b011;
    localparam logic [2:0] BR_GE   = 3'b100;
    localparam logic [2:0] BR_LTU  = 3'b101;
    localparam logic [2:0] BR_GEU  = 3'b110;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_mode_t;

endpackage

// File: rtl/alu_shifter.sv
// Iterative shifter: load captures data/amount/mode, each step shifts one bit
// and decrements the counter; done is high once the counter is zero.
module alu_shifter
    import rv32i_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] value,
    output logic             done
);

    logic [4:0] count;
    logic [1:0] mode_q;

    assign done = (count == 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value  <= '0;
            count  <= '0;
            mode_q <= SH_SLL;
        end else if (load) begin
            value  <= data;
            count  <= shamt;
            mode_q <= mode;
        end else if (step && !done) begin
            count <= count - 5'd1;
            case (mode_q)
                SH_SRL:  value <= {1'b0, value[WIDTH-1:1]};
                SH_SRA:  value <= {value[WIDTH-1], value[WIDTH-1:1]};
                default: value <= {value[WIDTH-2:0], 1'b0};
            endcase
        end
    end

endmodule

// File: rtl/alu_unit.sv
// Multi-cycle RV32I execute unit (IDLE -> CALC -> DONE -> WAIT).
// Define ALU_SLT_EN to add the slt/sltu operations.
module alu_unit
    import rv32i_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_en,
    input  logic [4:0]       alu_op,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_valid,
    output logic [2:0]       branch_op,
    output logic             busy
);

    logic [1:0]       state;
    logic [4:0]       op_q;
    logic [2:0]       func3_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] calc_result;
    logic [WIDTH-1:0] sh_value;
    logic             sh_done;
    logic             start;
    logic             is_shift_q;
    shift_mode_t      shift_mode;

    function automatic logic [2:0] branch_code(input logic [2:0] f3,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [2:0] code;
        code = BR_NONE;
        case (f3)
            3'b000: if (a == b)                   code = BR_EQ;
            3'b001: if (a != b)                   code = BR_NE;
            3'b100: if ($signed(a) <  $signed(b)) code = BR_LT;
            3'b101: if ($signed(a) >= $signed(b)) code = BR_GE;
            3'b110: if (a <  b)                   code = BR_LTU;
            3'b111: if (a >= b)                   code = BR_GEU;
            default: code = BR_NONE;
        endcase
        return code;
    endfunction

    assign start      = (state == ST_IDLE) && alu_en;
    assign busy       = (state != ST_IDLE);
    assign is_shift_q = (op_q == ALU_SLL) || (op_q == ALU_SRL) || (op_q == ALU_SRA);

    // The shifter is loaded straight from the ports on the start edge so its
    // first step can happen in the first CALC cycle.
    always_comb begin
        shift_mode = SH_SLL;
        if (alu_op == ALU_SRL) shift_mode = SH_SRL;
        if (alu_op == ALU_SRA) shift_mode = SH_SRA;
    end

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (start),
        .step  ((state == ST_CALC) && is_shift_q),
        .mode  (shift_mode),
        .data  (op_a),
        .shamt (op_b[4:0]),
        .value (sh_value),
        .done  (sh_done)
    );

    always_comb begin
        calc_result = '0;
        case (op_q)
            ALU_ADD, ALU_ADDR: calc_result = a_q + b_q;
            ALU_SUB:           calc_result = a_q - b_q;
            ALU_AND:           calc_result = a_q & b_q;
            ALU_OR:            calc_result = a_q | b_q;
            ALU_XOR:           calc_result = a_q ^ b_q;
`ifdef ALU_SLT_EN
            ALU_SLT:           calc_result = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            ALU_SLTU:          calc_result = {{(WIDTH-1){1'b0}}, a_q < b_q};
`endif
            default:           calc_result = '0;
        endcase
    end

    // WAIT only leaves once alu_en is seen low, so a late deassert cannot restart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            func3_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_result <= '0;
            alu_valid  <= 1'b0;
            branch_op  <= BR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (alu_en) begin
                        op_q    <= alu_op;
                        func3_q <= func3;
                        a_q     <= op_a;
                        b_q     <= op_b;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (!is_shift_q || sh_done) begin
                        alu_result <= is_shift_q ? sh_value : calc_result;
                        branch_op  <= branch_code(func3_q, a_q, b_q);
                        alu_valid  <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    alu_valid <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!alu_en) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit; expected values are hand-computed.
module tb_alu_unit;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_ADDR = 5'b11000;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01100;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_SLL  = 5'b01110;
    localparam logic [4:0] OP_SRL  = 5'b01111;
    localparam logic [4:0] OP_SRA  = 5'b10000;
    localparam logic [4:0] OP_SLT  = 5'b10001;
    localparam logic [4:0] OP_SLTU = 5'b10010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_en = 1'b0;
    logic [4:0]  alu_op = '0;
    logic [2:0]  func3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] alu_result;
    logic        alu_valid;
    logic [2:0]  branch_op;
    logic        busy;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .func3      (func3),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_result (alu_result),
        .alu_valid  (alu_valid),
        .branch_op  (branch_op),
        .busy       (busy)
    );

    // Starts an op, scrambles the inputs after the start edge, and returns the
    // cycle (1 = first cycle after the start edge) in which alu_valid is seen.
    task automatic run_op(input logic [4:0] op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output logic busy_all);
        @(negedge clk);
        alu_op = op; func3 = f3; op_a = a; op_b = b; alu_en = 1'b1;
        @(posedge clk);
        #1;
        alu_op = 5'b11111; func3 = ~f3; op_a = ~a; op_b = ~b;
        cycles = -1;
        busy_all = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (!busy) busy_all = 1'b0;
            if (alu_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic release_en();
        @(negedge clk);
        alu_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({alu_result, alu_valid, branch_op, busy} !== 37'd0)
            $display("[TB] FAIL reset_outputs: got result=%h valid=%b br=%b busy=%b, want all zero",
                     alu_result, alu_valid, branch_op, busy);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        int cyc; logic b_all; int pulses;
        run_op(OP_ADD, 3'b000, 32'h0000_0005, 32'hFFFF_FFFF, cyc, b_all);
        total++;
        if (cyc !== 2) $display("[TB] FAIL add_latency: got %0d want 2", cyc); else passed++;
        total++;
        if (alu_result !== 32'h0000_0004) $display("[TB] FAIL add_result: got %h want 00000004", alu_result); else passed++;
        total++;
        if (branch_op !== 3'b000) $display("[TB] FAIL add_branch: got %b want 000", branch_op); else passed++;
        @(negedge clk);
        total++;
        if (alu_valid !== 1'b0) $display("[TB] FAIL add_pulse_width: got valid=%b want 0", alu_valid); else passed++;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (alu_valid) pulses++;
        end
        total++;
        if (pulses !== 0) $display("[TB] FAIL add_no_retrigger: got %0d pulses want 0", pulses); else passed++;
        total++;
        if (busy !== 1'b1) $display("[TB] FAIL wait_busy: got %b want 1", busy); else passed++;
        @(negedge clk);
        alu_en = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("[TB] FAIL idle_after_release: got busy=%b want 0", busy); else passed++;
        total++;
        if (alu_result !== 32'h0000_0004) $display("[TB] FAIL result_held: got %h want 00000004", alu_result); else passed++;
    endtask

    task automatic test_sub_branch();
        int cyc; logic b_all;
        run_op(OP_SUB, 3'b100, 32'd3, 32'd5, cyc, b_all);
        total++;
        if (alu_result !== 32'hFFFF_FFFE) $display("[TB] FAIL sub_result: got %h want fffffffe", alu_result); else passed++;
        total++;
        if (branch_op !== 3'b011) $display("[TB] FAIL blt_taken: got %b want 011", branch_op); else passed++;
        release_en();
        run_op(OP_SUB, 3'b101, 32'd3, 32'd5, cyc, b_all);
        total++;
        if (branch_op !== 3'b000) $display("[TB] FAIL bge_not_taken: got %b want 000", branch_op); else passed++;
        release_en();
        run_op(OP_SUB, 3'b110, 32'd3, 32'd5, cyc, b_all);
        total++;
        if (branch_op !== 3'b101) $display("[TB] FAIL bltu_taken: got %b want 101", branch_op); else passed++;
        release_en();
        run_op(OP_ADD, 3'b111, 32'hFFFF_FFFF, 32'd1, cyc, b_all);
        total++;
        if (branch_op !== 3'b110) $display("[TB] FAIL bgeu_taken: got %b want 110", branch_op); else passed++;
        total++;
        if (alu_result !== 32'd0) $display("[TB] FAIL add_wrap: got %h want 00000000", alu_result); else passed++;
        release_en();
        run_op(OP_AND, 3'b001, 32'd7, 32'd9, cyc, b_all);
        total++;
        if (branch_op !== 3'b010) $display("[TB] FAIL bne_taken: got %b want 010", branch_op); else passed++;
        release_en();
        run_op(OP_OR, 3'b000, 32'd9, 32'd9, cyc, b_all);
        total++;
        if (branch_op !== 3'b001) $display("[TB] FAIL beq_taken: got %b want 001", branch_op); else passed++;
        release_en();
        run_op(OP_OR, 3'b010, 32'd9, 32'd9, cyc, b_all);
        total++;
        if (branch_op !== 3'b000) $display("[TB] FAIL br_other_func3: got %b want 000", branch_op); else passed++;
        release_en();
    endtask

    task automatic test_logic();
        int cyc; logic b_all;
        run_op(OP_AND, 3'b011, 32'hF0F0_00FF, 32'h0FF0_0F0F, cyc, b_all);
        total++;
        if (alu_result !== 32'h00F0_000F) $display("[TB] FAIL and_result: got %h want 00f0000f", alu_result); else passed++;
        release_en();
        run_op(OP_OR, 3'b011, 32'hF0F0_00FF, 32'h0FF0_0F0F, cyc, b_all);
        total++;
        if (alu_result !== 32'hFFF0_0FFF) $display("[TB] FAIL or_result: got %h want fff00fff", alu_result); else passed++;
        release_en();
        run_op(OP_XOR, 3'b011, 32'hF0F0_00FF, 32'h0FF0_0F0F, cyc, b_all);
        total++;
        if (alu_result !== 32'hFF00_0FF0) $display("[TB] FAIL xor_result: got %h want ff000ff0", alu_result); else passed++;
        total++;
        if (cyc !== 2) $display("[TB] FAIL xor_latency: got %0d want 2", cyc); else passed++;
        release_en();
        run_op(OP_ADDR, 3'b011, 32'h0000_1000, 32'h0000_0024, cyc, b_all);
        total++;
        if (alu_result !== 32'h0000_1024) $display("[TB] FAIL addr_result: got %h want 00001024", alu_result); else passed++;
        release_en();
        run_op(5'b11111, 3'b011, 32'h1234_5678, 32'h1, cyc, b_all);
        total++;
        if (alu_result !== 32'd0 || cyc !== 2)
            $display("[TB] FAIL unsupported_op: got result=%h cycles=%0d want 00000000 in 2", alu_result, cyc);
        else passed++;
        release_en();
    endtask

    task automatic test_shifts();
        int cyc; logic b_all;
        run_op(OP_SRA, 3'b011, 32'h8000_0000, 32'd4, cyc, b_all);
        total++;
        if (cyc !== 6) $display("[TB] FAIL sra_latency: got %0d want 6", cyc); else passed++;
        total++;
        if (alu_result !== 32'hF800_0000) $display("[TB] FAIL sra_result: got %h want f8000000", alu_result); else passed++;
        total++;
        if (b_all !== 1'b1) $display("[TB] FAIL sra_busy: got busy_all=%b want 1", b_all); else passed++;
        release_en();
        run_op(OP_SLL, 3'b011, 32'd1, 32'd0, cyc, b_all);
        total++;
        if (alu_result !== 32'd1 || cyc !== 2)
            $display("[TB] FAIL sll_shamt0: got result=%h cycles=%0d want 00000001 in 2", alu_result, cyc);
        else passed++;
        release_en();
        run_op(OP_SLL, 3'b011, 32'd1, 32'd31, cyc, b_all);
        total++;
        if (alu_result !== 32'h8000_0000 || cyc !== 33)
            $display("[TB] FAIL sll_shamt31: got result=%h cycles=%0d want 80000000 in 33", alu_result, cyc);
        else passed++;
        release_en();
        run_op(OP_SRL, 3'b011, 32'hF000_0000, 32'h0000_0024, cyc, b_all);
        total++;
        if (alu_result !== 32'h0F00_0000 || cyc !== 6)
            $display("[TB] FAIL srl_shamt_field: got result=%h cycles=%0d want 0f000000 in 6", alu_result, cyc);
        else passed++;
        release_en();
    endtask

    task automatic test_reset_mid_shift();
        int cyc; logic b_all;
        @(negedge clk);
        alu_op = OP_SLL; func3 = 3'b000; op_a = 32'd1; op_b = 32'd31; alu_en = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({alu_result, alu_valid, branch_op, busy} !== 37'd0)
            $display("[TB] FAIL async_reset: got result=%h valid=%b br=%b busy=%b, want all zero",
                     alu_result, alu_valid, branch_op, busy);
        else passed++;
        alu_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(OP_ADD, 3'b000, 32'd2, 32'd2, cyc, b_all);
        total++;
        if (alu_result !== 32'd4 || cyc !== 2)
            $display("[TB] FAIL add_after_reset: got result=%h cycles=%0d want 00000004 in 2", alu_result, cyc);
        else passed++;
        release_en();
    endtask

    task automatic test_slt();
        int cyc; logic b_all;
        logic [31:0] exp_slt;
        logic [31:0] exp_sltu;
`ifdef ALU_SLT_EN
        exp_slt  = 32'd1;
        exp_sltu = 32'd1;
`else
        exp_slt  = 32'd0;
        exp_sltu = 32'd0;
`endif
        run_op(OP_SLT, 3'b011, 32'hFFFF_FFFF, 32'd0, cyc, b_all);
        total++;
        if (alu_result !== exp_slt || cyc !== 2)
            $display("[TB] FAIL slt_op: got result=%h cycles=%0d want %h in 2", alu_result, cyc, exp_slt);
        else passed++;
        release_en();
        run_op(OP_SLTU, 3'b011, 32'd0, 32'd1, cyc, b_all);
        total++;
        if (alu_result !== exp_sltu || cyc !== 2)
            $display("[TB] FAIL sltu_op: got result=%h cycles=%0d want %h in 2", alu_result, cyc, exp_sltu);
        else passed++;
        release_en();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_branch();
        test_logic();
        test_shifts();
        test_reset_mid_shift();
        test_slt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
